// File: rtl/lfsr_7_pkg.sv
// Shared definitions for the 7-bit Fibonacci LFSR x^7+x^6+x^3+x+1 (period 127).
// History vectors are stored with bit i holding stage i+1, so bit 0 is the newest bit.
package lfsr_7_pkg;

   localparam int LFSR_W = 7;
   localparam logic [LFSR_W-1:0] TAP_MASK = 7'b110_0101;
   localparam int PERIOD = 127;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Next bit of the sequence from the last seven bits (stages 7, 6, 3, 1).
   function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] h);
      return ^(h & TAP_MASK);
   endfunction

endpackage

// File: rtl/lfsr_7_6_3_1_0_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   // Count up on inc, stick at all-ones, return to zero on clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= {W{1'b0}};
      end else if (clr) begin
         cnt <= {W{1'b0}};
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/lfsr_7_6_3_1_0_checker.sv
// Self-synchronising PRBS checker for the x^7+x^6+x^3+x+1 generator stream.
// Acquires lock from received bits, then free-runs a local reference and flags
// every mismatching bit. Optional feature macro LFSR_CHK_BITCNT_EN adds bit_cnt,
// the saturating count of bits checked while locked (BER = err_cnt / bit_cnt).
module lfsr_7_6_3_1_0_checker
   import lfsr_7_pkg::*;
#(
   parameter int LOCK_RUN = 16,
   parameter int BAD_THR  = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             din,
   input  logic             clr,
   output logic             lock,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
`ifdef LFSR_CHK_BITCNT_EN
   ,
   output logic [CNT_W+7-1:0] bit_cnt
`endif
);

   localparam logic [6:0] LOCK_RUN_V = 7'(LOCK_RUN);
   localparam logic [6:0] BAD_THR_V  = 7'(BAD_THR);
   localparam logic [6:0] WIN_LAST   = 7'(PERIOD - 1);

   chk_state_t        state_r;
   logic [LFSR_W-1:0] hist_r;
   logic [2:0]        fill_r;
   logic [6:0]        run_r;
   logic [6:0]        widx_r;
   logic [6:0]        werr_r;
   logic              lock_r;
   logic              err_r;

   logic              pred_s;
   logic              mis_s;
   logic              chk_s;
   logic              err_inc_s;

   assign pred_s    = lfsr_next_bit(hist_r);
   assign mis_s     = din ^ pred_s;
   assign chk_s     = ena && (state_r == LOCKED);
   assign err_inc_s = chk_s && mis_s;

   // Acquisition / tracking state machine; outputs lock and err are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FILL;
         hist_r  <= 7'd0;
         fill_r  <= 3'd0;
         run_r   <= 7'd0;
         widx_r  <= 7'd0;
         werr_r  <= 7'd0;
         lock_r  <= 1'b0;
         err_r   <= 1'b0;
      end else if (ena) begin
         case (state_r)
            FILL: begin
               err_r  <= 1'b0;
               hist_r <= {hist_r[5:0], din};
               if (fill_r == 3'd6) begin
                  state_r <= SEARCH;
                  fill_r  <= 3'd0;
                  run_r   <= 7'd0;
               end else begin
                  fill_r <= fill_r + 3'd1;
               end
            end
            SEARCH: begin
               err_r  <= 1'b0;
               hist_r <= {hist_r[5:0], din};
               // An all-zero history predicts zero forever and must not build a run.
               if (!mis_s && (hist_r != 7'd0)) begin
                  if ((run_r + 7'd1) == LOCK_RUN_V) begin
                     state_r <= LOCKED;
                     lock_r  <= 1'b1;
                     run_r   <= 7'd0;
                     widx_r  <= 7'd0;
                     werr_r  <= 7'd0;
                  end else begin
                     run_r <= run_r + 7'd1;
                  end
               end else begin
                  run_r <= 7'd0;
               end
            end
            LOCKED: begin
               // Reference free-runs on its own prediction so one bad bit is one error.
               err_r  <= mis_s;
               hist_r <= {hist_r[5:0], pred_s};
               if (mis_s && ((werr_r + 7'd1) == BAD_THR_V)) begin
                  state_r <= FILL;
                  lock_r  <= 1'b0;
                  hist_r  <= 7'd0;
                  fill_r  <= 3'd0;
                  widx_r  <= 7'd0;
                  werr_r  <= 7'd0;
               end else if (widx_r == WIN_LAST) begin
                  widx_r <= 7'd0;
                  werr_r <= 7'd0;
               end else begin
                  widx_r <= widx_r + 7'd1;
                  werr_r <= werr_r + {6'd0, mis_s};
               end
            end
            default: begin
               state_r <= FILL;
               hist_r  <= 7'd0;
               fill_r  <= 3'd0;
               run_r   <= 7'd0;
               widx_r  <= 7'd0;
               werr_r  <= 7'd0;
               lock_r  <= 1'b0;
               err_r   <= 1'b0;
            end
         endcase
      end else begin
         err_r <= 1'b0;
      end
   end

   assign lock = lock_r;
   assign err  = err_r;

   lfsr_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc_s),
      .clr   (clr),
      .cnt   (err_cnt)
   );

`ifdef LFSR_CHK_BITCNT_EN
   lfsr_sat_cnt #(.W(CNT_W + 7)) u_bit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (chk_s),
      .clr   (clr),
      .cnt   (bit_cnt)
   );
`endif

endmodule

// File: tb/tb_lfsr_7_6_3_1_0_checker.sv
// Randomised self-checking bench for lfsr_7_6_3_1_0_checker against a queue-based model.
module tb_lfsr_7_6_3_1_0_checker;

   localparam int LOCK_RUN = 16;
   localparam int BAD_THR  = 8;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic        din;
   logic        clr;
   logic        lock,  lock4;
   logic        err,   err4;
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt4;
`ifdef LFSR_CHK_BITCNT_EN
   logic [22:0] bit_cnt;
   logic [10:0] bit_cnt4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   lfsr_7_6_3_1_0_checker #(.LOCK_RUN(LOCK_RUN), .BAD_THR(BAD_THR), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .clr(clr),
      .lock(lock), .err(err), .err_cnt(err_cnt)
`ifdef LFSR_CHK_BITCNT_EN
      , .bit_cnt(bit_cnt)
`endif
   );

   lfsr_7_6_3_1_0_checker #(.LOCK_RUN(LOCK_RUN), .BAD_THR(BAD_THR), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .clr(clr),
      .lock(lock4), .err(err4), .err_cnt(err_cnt4)
`ifdef LFSR_CHK_BITCNT_EN
      , .bit_cnt(bit_cnt4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus generator: s[n] = s[n-1]^s[n-3]^s[n-6]^s[n-7]
   bit g_q[$];   // g_q[0] is the newest bit
   function automatic bit gen_next();
      bit b;
      b = g_q[0] ^ g_q[2] ^ g_q[5] ^ g_q[6];
      g_q.push_front(b);
      void'(g_q.pop_back());
      return b;
   endfunction

   // ---------------- behavioural reference model
   int     m_mode;      // 0 acquiring history, 1 searching, 2 locked
   bit     m_hist[$];   // received/reference bits, newest at the back
   int     m_run, m_widx, m_werr;
   longint m_errc, m_errc4, m_bitc, m_bitc4;
   bit     m_lock, m_err;

   function automatic longint sat_inc(input longint v, input longint maxv);
      return (v < maxv) ? v + 1 : v;
   endfunction

   function automatic bit m_pred();
      int n;
      n = m_hist.size();
      return m_hist[n-1] ^ m_hist[n-3] ^ m_hist[n-6] ^ m_hist[n-7];
   endfunction

   function automatic void m_reset();
      m_mode = 0; m_hist.delete();
      m_run = 0; m_widx = 0; m_werr = 0;
      m_errc = 0; m_errc4 = 0; m_bitc = 0; m_bitc4 = 0;
      m_lock = 0; m_err = 0;
   endfunction

   function automatic void m_step(input bit e, input bit d, input bit c);
      bit p, bad;
      int ones;
      m_err = 0;
      if (e) begin
         if (m_mode == 0) begin
            m_hist.push_back(d);
            if (m_hist.size() == 7) begin
               m_mode = 1;
               m_run  = 0;
            end
         end else if (m_mode == 1) begin
            p = m_pred();
            ones = 0;
            foreach (m_hist[i]) ones += int'(m_hist[i]);
            if (d == p && ones != 0) m_run++;
            else m_run = 0;
            m_hist.push_back(d);
            void'(m_hist.pop_front());
            if (m_run == LOCK_RUN) begin
               m_mode = 2; m_lock = 1; m_widx = 0; m_werr = 0;
            end
         end else begin
            p   = m_pred();
            bad = (d != p);
            m_err = bad;
            m_hist.push_back(p);
            void'(m_hist.pop_front());
            m_bitc  = sat_inc(m_bitc,  (64'd1 << 23) - 1);
            m_bitc4 = sat_inc(m_bitc4, (64'd1 << 11) - 1);
            if (bad) begin
               m_errc  = sat_inc(m_errc,  65535);
               m_errc4 = sat_inc(m_errc4, 15);
               m_werr++;
            end
            if (m_werr == BAD_THR) begin
               m_mode = 0; m_lock = 0; m_hist.delete();
            end else if (m_widx == 126) begin
               m_widx = 0; m_werr = 0;
            end else begin
               m_widx++;
            end
         end
      end
      if (c) begin
         m_errc = 0; m_errc4 = 0; m_bitc = 0; m_bitc4 = 0;
      end
   endfunction

   // One clock: drive at negedge, model steps with the edge, compare #1 later.
   task automatic cycle(input bit e, input bit d, input bit c);
      ena = e; din = d; clr = c;
      @(posedge clk);
      m_step(e, d, c);
      #1;
      check_val("lock",     lock,     m_lock);
      check_val("err",      err,      m_err);
      check_val("err_cnt",  err_cnt,  m_errc);
      check_val("lock4",    lock4,    m_lock);
      check_val("err_cnt4", err_cnt4, m_errc4);
`ifdef LFSR_CHK_BITCNT_EN
      check_val("bit_cnt",  bit_cnt,  m_bitc);
      check_val("bit_cnt4", bit_cnt4, m_bitc4);
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b0; din = 1'b0; clr = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      check_val("rst_lock",    lock,    0);
      check_val("rst_err",     err,     0);
      check_val("rst_err_cnt", err_cnt, 0);
      rst_n = 1'b1;
   endtask

   // Run clean bits until the model window index equals target (bounded).
   task automatic align_window(input int target);
      int k;
      k = 0;
      while (m_widx != target && k < 300) begin
         cycle(1'b1, gen_next(), 1'b0);
         k++;
      end
      check_val("align_window", m_widx, target);
   endtask

   initial begin
      int lock_at, pulses, k, acc;
      bit e, d, f;
      g_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      rst_n = 1'b0; ena = 1'b0; din = 1'b0; clr = 1'b0;
      @(negedge clk);

      // 1: clean stream from reset
      do_reset();
      lock_at = 0; pulses = 0;
      for (int i = 1; i <= 381; i++) begin
         cycle(1'b1, gen_next(), 1'b0);
         if (lock && lock_at == 0) lock_at = i;
         if (err) pulses++;
      end
      check_val("s1_lock_at",   lock_at, 23);
      check_val("s1_err_pulse", pulses,  0);
      check_val("s1_err_cnt",   err_cnt, 0);
`ifdef LFSR_CHK_BITCNT_EN
      check_val("s1_bit_cnt",   bit_cnt, 358);
`endif

      // 2: single flipped bit
      cycle(1'b1, gen_next(), 1'b1);
      repeat (20) cycle(1'b1, gen_next(), 1'b0);
      pulses = 0;
      cycle(1'b1, ~gen_next(), 1'b0);
      if (err) pulses++;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, gen_next(), 1'b0);
         if (err) pulses++;
      end
      check_val("s2_pulses",  pulses,  1);
      check_val("s2_err_cnt", err_cnt, 1);
      check_val("s2_lock",    lock,    1);

      // 3a: eight errors in one window lose lock, then relock after 23 bits
      align_window(1);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, ~gen_next(), 1'b0);
         if (i < 7) repeat (3) cycle(1'b1, gen_next(), 1'b0);
      end
      check_val("s3_lock_lost", lock,    0);
      check_val("s3_err_cnt",   err_cnt, 9);
      lock_at = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b1, gen_next(), 1'b0);
         if (lock && lock_at == 0) lock_at = i;
      end
      check_val("s3_relock_at", lock_at, 23);

      // 3b: seven errors in one window keep lock
      align_window(1);
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, ~gen_next(), 1'b0);
         repeat (3) cycle(1'b1, gen_next(), 1'b0);
      end
      check_val("s3_lock_held", lock,    1);
      check_val("s3_err_cnt7", err_cnt, 16);

      // 4: all-zero stream never locks; the real stream then locks within 23 bits
      do_reset();
      lock_at = 0;
      for (int i = 1; i <= 200; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (lock && lock_at == 0) lock_at = i;
      end
      check_val("s4_zero_lock", lock_at, 0);
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b1, gen_next(), 1'b0);
         if (lock && lock_at == 0) lock_at = i;
      end
      check_val("s4_lock_by_23", (lock_at > 0 && lock_at <= 23) ? 1 : 0, 1);

      // 5: random ENA; lock timing counted in accepted bits
      do_reset();
      lock_at = 0; acc = 0; k = 0;
      while (lock_at == 0 && k < 200) begin
         e = ($urandom_range(1) == 1);
         d = e ? gen_next() : 1'($urandom_range(1));
         cycle(e, d, 1'b0);
         if (e) acc++;
         if (lock && lock_at == 0) lock_at = acc;
         k++;
      end
      check_val("s5_lock_at_acc", lock_at, 23);
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(1) == 1);
         f = ($urandom_range(63) == 0);
         d = e ? (gen_next() ^ f) : 1'($urandom_range(1));
         cycle(e, d, ($urandom_range(49) == 0));
      end

      // 5b: CLR coincident with an error
      k = 0;
      while (!m_lock && k < 100) begin
         cycle(1'b1, gen_next(), 1'b0);
         k++;
      end
      check_val("s5_locked", lock, 1);
      cycle(1'b1, ~gen_next(), 1'b1);
      check_val("s5_clr_err",     err,     1);
      check_val("s5_clr_err_cnt", err_cnt, 0);

      // 6: saturation of the 4-bit counter over three windows (7 errors each)
      align_window(0);
      cycle(1'b1, gen_next(), 1'b1);
      align_window(0);
      for (int i = 0; i < 381; i++) begin
         f = m_lock && (m_widx % 20 == 3);
         cycle(1'b1, gen_next() ^ f, 1'b0);
      end
      check_val("s6_lock",      lock,     1);
      check_val("s6_err_cnt",   err_cnt,  21);
      check_val("s6_err_cnt4",  err_cnt4, 15);

      // 7: asynchronous reset between edges while locked and ERR high
      cycle(1'b1, ~gen_next(), 1'b0);
      check_val("s7_pre_err",  err,  1);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check_val("s7_lock",     lock,     0);
      check_val("s7_err",      err,      0);
      check_val("s7_err_cnt",  err_cnt,  0);
      check_val("s7_err_cnt4", err_cnt4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) cycle(1'b1, gen_next(), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
